// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg
//   Constants shared by the UART receive and transmit paths:
//   - the UART byte width and the byte type built from it;
//   - the two-state ingest handshake encoding (idle / acknowledge).
package uart_rx_fifo_pkg;

    localparam int UART_BYTE_W = 8;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

    localparam logic [0:0] ING_IDLE = 1'b0;
    localparam logic [0:0] ING_ACK  = 1'b1;

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// fifo_ram
//   DEPTH x 8 simple dual-port memory: one synchronous write port and one
//   synchronous read port. Neither the array nor the read register is reset.
//   Ports:
//     clk            system clock
//     we/waddr/wdata write strobe, address and byte
//     re/raddr       read strobe and address
//     rdata          read register, updated only on a read strobe
module fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  uart_byte_t            wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output uart_byte_t            rdata
);

    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer behind the UART receiver. Drains the receiver's holding
//   register into a DEPTH-entry circular FIFO and offers a CPU pop port.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     rx_full, rx_data     receiver holding register flag and contents
//     rx_re                one-cycle acknowledge back to the receiver
//     rd                   CPU pop strobe
//     rd_data, rd_valid    popped byte (registered) and its one-cycle valid
//     empty, full, count   occupancy status
//     stall, stall_clr     sticky backpressure flag and its clear
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_full,
    input  logic [7:0]            rx_data,
    output logic                  rx_re,
    input  logic                  rd,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  stall,
    input  logic                  stall_clr
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [0:0]            ing_state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_loaded;
    logic                  wr_en;
    logic                  rd_en;
    logic                  offer_blocked;
    uart_byte_t            ram_q;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // The ACK state skips the cycle in which the receiver's full flag is
    // still high for the byte just taken, so each byte is written once.
    // Admission looks at full from the registered count only; a pop in the
    // same cycle does not open a slot until the next idle evaluation.
    assign wr_en         = !rst && (ing_state == ING_IDLE) && rx_full && !full;
    assign offer_blocked = (ing_state == ING_IDLE) && rx_full && full;
    assign rd_en         = !rst && rd && !empty;

    // The RAM read register has no reset, so rd_data is forced to zero
    // until the first pop after reset loads it.
    assign rd_data = rd_loaded ? ram_q : 8'h00;

    fifo_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ing_state <= ING_IDLE;
            rx_re     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            rd_loaded <= 1'b0;
            stall     <= 1'b0;
        end else begin
            if (wr_en) begin
                ing_state <= ING_ACK;
                rx_re     <= 1'b1;
                wr_ptr    <= wr_ptr + 1'b1;
            end else begin
                ing_state <= ING_IDLE;
                rx_re     <= 1'b0;
            end

            if (rd_en) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_loaded <= 1'b1;
            end
            rd_valid <= rd_en;

            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A new backpressure event outranks a clear in the same cycle.
            if (offer_blocked) begin
                stall <= 1'b1;
            end else if (stall_clr) begin
                stall <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Drains the receiver's single-byte holding register into a DEPTH-entry circular FIFO using the receiver's full/re handshake.
- Presents a CPU-side pop interface with occupancy and status flags, so software tolerates bursts without dropping bytes.
- Applies backpressure by leaving the receiver's full flag set when the FIFO is full.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- ADDR_WIDTH, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- rx_full  input  1  receiver holding register contains a byte (receiver "full").
- rx_data  input  8  receiver holding register contents (receiver "dout").
- rx_re  output  1  one-cycle acknowledge to receiver; clears its full flag on the following edge.
- rd  input  1  CPU pop strobe, one cycle per byte.
- rd_data  output  8  popped byte, registered.
- rd_valid  output  1  high for exactly one cycle, one cycle after an accepted rd.
- empty  output  1  FIFO holds zero bytes.
- full  output  1  FIFO holds DEPTH bytes.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- stall  output  1  sticky: backpressure was applied to the receiver.
- stall_clr  input  1  clears stall.

Behaviour:
- Reset values (rst high at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
  - rx_re=0, rd_valid=0, rd_data=8'h00, stall=0.
  - Ingest FSM returns to IDLE.
  - Memory contents are not reset.
- Ingest FSM, states IDLE and ACK:
  - IDLE: if rx_full && !full, then on that edge write rx_data to mem[wr_ptr], wr_ptr+1, drive rx_re=1 for the next cycle, and go to ACK.
  - IDLE, otherwise: stay, rx_re=0.
  - ACK: rx_re=0; ignore rx_full, because the receiver's full is still high this cycle; return to IDLE.
  - Each received byte is written exactly once. Maximum ingest rate is 1 byte per 2 clocks, far above the UART line rate.
- Capture timing: rx_data is sampled on the same edge the write is taken. The receiver holds its output stable while full is high.
- Backpressure:
  - If rx_full && full in IDLE: no write, rx_re stays 0, the receiver stays full and ignores new start bits.
  - stall sets to 1 on that edge.
  - stall clears only on stall_clr or rst. If set and clear occur in the same cycle, set wins.
- Pop:
  - rd && !empty: rd_data <= mem[rd_ptr], rd_ptr+1, rd_valid=1 next cycle.
  - rd && empty: ignored; rd_valid=0, rd_data holds, no flag changes.
- Simultaneous write and pop in one cycle: both take effect and count is unchanged.
- Write admission uses full as registered at the start of the cycle. A concurrent pop does not allow a write into a full FIFO that same cycle; the write occurs on the next IDLE evaluation.
- Pointers wrap modulo DEPTH (natural ADDR_WIDTH overflow).
- count increments on write-only, decrements on pop-only, holds otherwise.
- empty = (count==0), full = (count==DEPTH), both registered or derived from registered count.
- Ordering is strict FIFO; no byte is duplicated or lost while full==0.
- Reset mid-operation:
  - FIFO contents are discarded.
  - A byte held in the receiver at reset is not acknowledged; it is ingested normally after rst deasserts.
  - rx_re is 0 during reset.

Decomposition:
- Shared package/include: FSM state constants (ING_IDLE=0, ING_ACK=1) and the UART byte width constant (8), reused by receiver and transmitter paths.
- One sub-module: fifo_ram, a DEPTH x 8 simple dual-port memory with synchronous write and synchronous read, no reset. Pointer, count, FSM and flag logic live in uart_rx_fifo.

Test Plan:
- Ingest with no pop:
  - Stimulus: rx_full high with rx_data=8'hA5, receiver model drops full one cycle after rx_re.
  - Required: exactly one rx_re pulse, count=1, empty=0.
  - Then rd: rd_valid one cycle later with rd_data=8'hA5, count=0, empty=1.
- Fill to full:
  - Stimulus: 16 bytes 8'h00..8'h0F, then 8'h10 offered.
  - Required: full=1, count=16.
  - 17th byte gets no rx_re and stall=1. After one rd returning 8'h00, 8'h10 is ingested and count=16.
- Pop order:
  - Stimulus: drain all 16.
  - Required: rd_data sequence 8'h01..8'h10; no rd_valid on a further rd with empty=1.
- Wrap-around:
  - Stimulus: 40 bytes interleaved with pops, occupancy never above 5.
  - Required: output sequence matches input exactly; count is never negative and never above 5.
- Simultaneous write and pop:
  - Stimulus: count=3, ingest 8'h77 in the same cycle as rd.
  - Required: count stays 3; 8'h77 emerges fourth.
- Reset and stall clear:
  - Stimulus: with count=7 and stall=1, assert rst for one cycle while rx_full is high.
  - Required: count=0, stall=0, rx_re=0 during reset; the byte is ingested after release.
  - Also: stall_clr pulse alone clears stall.
